// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: two read ports, one write port, clear request and ready flag.
// The datapath side uses the master modport and the register file uses the slave modport.
interface param_register_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              clear;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ready;

  modport master (
    output clear, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    input  rd_data1, rd_data2, ready
  );

  modport slave (
    input  clear, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
    output rd_data1, rd_data2, ready
  );
endinterface

// File: rtl/param_register_file.sv
// 2-read/1-write register file with registered reads, optional hardwired zero entry and a
// sequential self-clear walk. Optional macro REGFILE_BYPASS_EN forwards same-edge writes to reads.
module param_register_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  param_register_file_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              ready_q, ready_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              restart;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_fire;
  logic              hit1, hit2;

  logic [DATA_W-1:0] rd_data1_d, rd_data2_d;
  logic [DATA_W-1:0] rd_data1_p1, rd_data2_p1;

  // Entry 0 reads as zero when hardwired; reads outside RUN always return zero.
  function automatic logic [DATA_W-1:0] read_sel(
    input logic              in_run,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] entry,
    input logic              fwd_hit,
    input logic [DATA_W-1:0] fwd_data
  );
    if (!in_run)                          return '0;
    if ((ZERO_REG != 0) && (addr == '0))  return '0;
    if (fwd_hit)                          return fwd_data;
    return entry;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign run     = (state_q == RUN);
  assign restart = reset || bus.clear;
  assign wr_fire = run && !restart && bus.wr_en && !is_zero_reg(bus.wr_addr);

`ifdef REGFILE_BYPASS_EN
  assign hit1 = wr_fire && (bus.wr_addr == bus.rd_addr1);
  assign hit2 = wr_fire && (bus.wr_addr == bus.rd_addr2);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  // Control FSM: reset and clear both restart the walk; clear leaves the read registers alone.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    if (restart) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_idx_d = clr_idx_q + 1'b1;
          if (clr_idx_q == {ADDR_W{1'b1}}) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end
        RUN:     ;
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  // Single memory write port shared between the clear walk and the writeback port.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (!restart && !run) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdata = '0;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rd_data1_d = read_sel(run, bus.rd_addr1, mem[bus.rd_addr1], hit1, bus.wr_data);
    rd_data2_d = read_sel(run, bus.rd_addr2, mem[bus.rd_addr2], hit2, bus.wr_data);
  end

  // ---- read stage p1 ----
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data1_p1 <= '0;
      rd_data2_p1 <= '0;
    end else begin
      rd_data1_p1 <= rd_data1_d;
      rd_data2_p1 <= rd_data2_d;
    end
  end

  assign bus.rd_data1 = rd_data1_p1;
  assign bus.rd_data2 = rd_data2_p1;
  assign bus.ready    = ready_q;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: a ZERO_REG=1 and a ZERO_REG=0 instance share stimulus.
// Expected same-edge read values follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_param_register_file;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  param_register_file_if #(.DATA_W(16), .ADDR_W(5)) bus0 ();
  param_register_file_if #(.DATA_W(16), .ADDR_W(5)) bus1 ();

  assign bus1.clear    = bus0.clear;
  assign bus1.rd_addr1 = bus0.rd_addr1;
  assign bus1.rd_addr2 = bus0.rd_addr2;
  assign bus1.wr_en    = bus0.wr_en;
  assign bus1.wr_addr  = bus0.wr_addr;
  assign bus1.wr_data  = bus0.wr_data;

  param_register_file #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  param_register_file #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(0)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

`ifdef REGFILE_BYPASS_EN
  localparam logic [15:0] R5_SAME  = 16'hBEEF;
  localparam logic [15:0] R0_SAME  = 16'h5555;
  localparam logic [15:0] R31_SAME = 16'h8001;
`else
  localparam logic [15:0] R5_SAME  = 16'h0001;
  localparam logic [15:0] R0_SAME  = 16'h1234;
  localparam logic [15:0] R31_SAME = 16'hFFFF;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [15:0] e1;   // ZERO_REG=1 instance, port 1
    logic [15:0] e2;
    logic [15:0] z1;   // ZERO_REG=0 instance, port 1
    logic [15:0] z2;
  } vec_t;

  vec_t tbl [15];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   edges;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus0.ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      bus0.rd_addr1 = 5'(a);
      bus0.rd_addr2 = 5'(31 - a);
      tick();
      check({tag, "_rd1"},   bus0.rd_data1, 16'h0000);
      check({tag, "_rd2"},   bus0.rd_data2, 16'h0000);
      check({tag, "_z_rd1"}, bus1.rd_data1, 16'h0000);
      check({tag, "_z_rd2"}, bus1.rd_data2, 16'h0000);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 5'd1,  16'h3A5C, 5'd0,  5'd0,  16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 5'd2,  16'h00FF, 5'd1,  5'd1,  16'h3A5C, 16'h3A5C, 16'h3A5C, 16'h3A5C};
    tbl[2]  = '{1'b1, 5'd31, 16'hFFFF, 5'd2,  5'd0,  16'h00FF, 16'h0000, 16'h00FF, 16'h0000};
    tbl[3]  = '{1'b0, 5'd0,  16'h0000, 5'd1,  5'd31, 16'h3A5C, 16'hFFFF, 16'h3A5C, 16'hFFFF};
    tbl[4]  = '{1'b1, 5'd0,  16'h1234, 5'd2,  5'd1,  16'h00FF, 16'h3A5C, 16'h00FF, 16'h3A5C};
    tbl[5]  = '{1'b0, 5'd0,  16'h0000, 5'd0,  5'd0,  16'h0000, 16'h0000, 16'h1234, 16'h1234};
    tbl[6]  = '{1'b1, 5'd5,  16'h0001, 5'd3,  5'd4,  16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[7]  = '{1'b1, 5'd5,  16'hBEEF, 5'd5,  5'd2,  R5_SAME,  16'h00FF, R5_SAME,  16'h00FF};
    tbl[8]  = '{1'b0, 5'd0,  16'h0000, 5'd5,  5'd5,  16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    tbl[9]  = '{1'b1, 5'd0,  16'h5555, 5'd0,  5'd0,  16'h0000, 16'h0000, R0_SAME,  R0_SAME};
    tbl[10] = '{1'b0, 5'd0,  16'h0000, 5'd0,  5'd31, 16'h0000, 16'hFFFF, 16'h5555, 16'hFFFF};
    tbl[11] = '{1'b1, 5'd31, 16'h8001, 5'd1,  5'd31, 16'h3A5C, R31_SAME, 16'h3A5C, R31_SAME};
    tbl[12] = '{1'b0, 5'd0,  16'h0000, 5'd31, 5'd31, 16'h8001, 16'h8001, 16'h8001, 16'h8001};
    tbl[13] = '{1'b1, 5'd7,  16'hAAAA, 5'd1,  5'd2,  16'h3A5C, 16'h00FF, 16'h3A5C, 16'h00FF};
    tbl[14] = '{1'b0, 5'd0,  16'h0000, 5'd7,  5'd7,  16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA};

    reset         = 1'b1;
    bus0.clear    = 1'b0;
    bus0.wr_en    = 1'b0;
    bus0.wr_addr  = '0;
    bus0.wr_data  = '0;
    bus0.rd_addr1 = '0;
    bus0.rd_addr2 = '0;

    // Reset held for three edges: the walk must not advance until it drops.
    repeat (3) tick();
    check("rst_ready", 16'(bus0.ready), 16'h0000);
    check("rst_rd1",   bus0.rd_data1, 16'h0000);
    check("rst_rd2",   bus0.rd_data2, 16'h0000);
    reset = 1'b0;
    wait_ready(edges);
    check("rst_walk_edges", 16'(edges), 16'd32);
    read_all_zero("init");

    for (int i = 0; i < 15; i++) begin
      bus0.wr_en    = tbl[i].we;
      bus0.wr_addr  = tbl[i].wa;
      bus0.wr_data  = tbl[i].wd;
      bus0.rd_addr1 = tbl[i].ra1;
      bus0.rd_addr2 = tbl[i].ra2;
      tick();
      check($sformatf("vec%0d_rd1", i),   bus0.rd_data1, tbl[i].e1);
      check($sformatf("vec%0d_rd2", i),   bus0.rd_data2, tbl[i].e2);
      check($sformatf("vec%0d_z_rd1", i), bus1.rd_data1, tbl[i].z1);
      check($sformatf("vec%0d_z_rd2", i), bus1.rd_data2, tbl[i].z2);
    end
    bus0.wr_en = 1'b0;

    // Clear in RUN with a competing write: ready drops, reads go to zero during the walk.
    bus0.clear    = 1'b1;
    bus0.wr_en    = 1'b1;
    bus0.wr_addr  = 5'd9;
    bus0.wr_data  = 16'h9999;
    tick();
    bus0.clear    = 1'b0;
    bus0.wr_en    = 1'b0;
    bus0.rd_addr1 = 5'd7;
    bus0.rd_addr2 = 5'd1;
    check("clr_run_ready", 16'(bus0.ready), 16'h0000);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("walk_rd1", bus0.rd_data1, 16'h0000);
      check("walk_rd2", bus0.rd_data2, 16'h0000);
    end
    check("walk_ready_low", 16'(bus0.ready), 16'h0000);

    // Clear again at walk index 10 with a write on the same edge: the walk restarts from 0.
    bus0.clear   = 1'b1;
    bus0.wr_en   = 1'b1;
    bus0.wr_addr = 5'd3;
    bus0.wr_data = 16'h7777;
    tick();
    bus0.clear   = 1'b0;
    bus0.wr_en   = 1'b0;
    wait_ready(edges);
    check("restart_walk_edges", 16'(edges), 16'd32);
    check("ready_edge_rd1", bus0.rd_data1, 16'h0000);
    tick();
    check("r7_after_clear", bus0.rd_data1, 16'h0000);
    check("r1_after_clear", bus0.rd_data2, 16'h0000);
    read_all_zero("post");

    // Reset from RUN clears the read registers and ready on the same edge.
    bus0.wr_en    = 1'b1;
    bus0.wr_addr  = 5'd4;
    bus0.wr_data  = 16'hC3C3;
    tick();
    bus0.wr_en    = 1'b0;
    bus0.rd_addr1 = 5'd4;
    tick();
    check("r4_write", bus0.rd_data1, 16'hC3C3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_ready", 16'(bus0.ready), 16'h0000);
    check("rst2_rd1",   bus0.rd_data1, 16'h0000);
    wait_ready(edges);
    check("rst2_walk_edges", 16'(edges), 16'd32);
    tick();
    check("r4_after_reset", bus0.rd_data1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
